id_ex_barrier: RTL and testbench

ID_EX_BARRIER -- requirements
Module: id_ex_barrier

---
 rtl/core_pkg.sv | 56 +++++
 rtl/load_use_detect.sv | 28 ++
 rtl/id_ex_barrier.sv | 175 +++++++++++++++++
 tb/tb_id_ex_barrier.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the ID/EX pipeline barrier.
//   - Field widths of the decoded instruction datapath.
//   - Barrier FSM state encoding (RUN / HOLD / BUBBLE, 2 bits).
//   - Packed bundles for the control and datapath halves of the barrier.
//   - Saturating increment helper for the bubble counter.
package core_pkg;

  localparam int XLEN     = 32;
  localparam int IMM      = 64;
  localparam int REG_IDX  = 5;
  localparam int ALU_BASE = 3;
  localparam int ALU_EXT  = 7;
  localparam int CNT_W    = 16;

  localparam logic [CNT_W-1:0] STALL_COUNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_HOLD   = 2'b01,
    ST_BUBBLE = 2'b10
  } barrier_state_e;

  // Control half: everything that must read as zero in a bubble.
  typedef struct packed {
    logic [REG_IDX-1:0]  reg_write_target;
    logic                reg_write;
    logic                reg_write_from_load;
    logic [ALU_BASE-1:0] alu_op_base;
    logic [ALU_EXT-1:0]  alu_op_ext;
    logic                alu_src;
    logic                is_branch;
    logic                mem_write;
    logic                mem_read;
    logic                is_write_back;
  } ex_ctrl_t;

  // Datapath half: held (not cleared) when a bubble is inserted.
  typedef struct packed {
    logic [XLEN-1:0] first_reg;
    logic [XLEN-1:0] second_reg;
    logic [IMM-1:0]  sign_extended;
    logic [XLEN-1:0] pc_value;
  } ex_data_t;

  // Add one unless already at the ceiling; the counter never wraps.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    logic [CNT_W-1:0] result;
    if (value == STALL_COUNT_MAX) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector (purely combinational).
// Flags when the instruction in EX is a valid load whose destination (non-x0)
// is a source of the valid instruction currently in ID.
// Ports:
//   ex_valid, ex_mem_read, ex_rd : state of the instruction held in EX
//   id_valid, id_rs1, id_rs2     : decoded instruction waiting in ID
//   load_use                     : hazard present this cycle
module load_use_detect
  import core_pkg::*;
(
  input  logic               ex_valid,
  input  logic               ex_mem_read,
  input  logic [REG_IDX-1:0] ex_rd,
  input  logic               id_valid,
  input  logic [REG_IDX-1:0] id_rs1,
  input  logic [REG_IDX-1:0] id_rs2,
  output logic               load_use
);

  logic rd_match_s;

  // Destination/source compare; x0 is never a real dependency.
  always_comb begin
    rd_match_s = (ex_rd == id_rs1) | (ex_rd == id_rs2);
    load_use   = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid & rd_match_s;
  end

endmodule

// File: rtl/id_ex_barrier.sv
// ID/EX pipeline barrier with load-use bubble insertion, downstream hold and
// flush.
// Priority each cycle: rst > flush > ext_stall > load-use hazard > capture.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   id_*                   : decoded instruction fields and controls from ID
//   flush                  : kill barrier contents (taken branch downstream)
//   ext_stall              : freeze barrier (memory not ready)
//   ex_*                   : registered copies of the id_* fields, ex_valid
//   hazard_stall           : combinational freeze request for PC and IF/ID
//   stall_count            : saturating count of inserted load-use bubbles
// STALL_COUNT_RST sets the value stall_count takes on reset (normally zero).
module id_ex_barrier
  import core_pkg::*;
#(
  parameter logic [CNT_W-1:0] STALL_COUNT_RST = 16'h0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_IDX-1:0]  id_rs1,
  input  logic [REG_IDX-1:0]  id_rs2,
  input  logic [XLEN-1:0]     id_first_reg,
  input  logic [XLEN-1:0]     id_second_reg,
  input  logic [IMM-1:0]      id_sign_extended,
  input  logic [XLEN-1:0]     id_pc_value,
  input  logic [REG_IDX-1:0]  id_reg_write_target,
  input  logic                id_reg_write,
  input  logic                id_reg_write_from_load,
  input  logic [ALU_BASE-1:0] id_ALU_op_base,
  input  logic [ALU_EXT-1:0]  id_ALU_op_ext,
  input  logic                id_ALU_src,
  input  logic                id_is_branch,
  input  logic                id_mem_write,
  input  logic                id_mem_read,
  input  logic                id_is_write_back,
  input  logic                flush,
  input  logic                ext_stall,
  output logic                ex_valid,
  output logic [XLEN-1:0]     ex_first_reg,
  output logic [XLEN-1:0]     ex_second_reg,
  output logic [IMM-1:0]      ex_sign_extended,
  output logic [XLEN-1:0]     ex_pc_value,
  output logic [REG_IDX-1:0]  ex_reg_write_target,
  output logic                ex_reg_write,
  output logic                ex_reg_write_from_load,
  output logic [ALU_BASE-1:0] ex_ALU_op_base,
  output logic [ALU_EXT-1:0]  ex_ALU_op_ext,
  output logic                ex_ALU_src,
  output logic                ex_is_branch,
  output logic                ex_mem_write,
  output logic                ex_mem_read,
  output logic                ex_is_write_back,
  output logic                hazard_stall,
  output logic [CNT_W-1:0]    stall_count
);

  barrier_state_e   state_r;
  barrier_state_e   state_next_s;
  logic             valid_r;
  logic             valid_next_s;
  ex_ctrl_t         ctrl_r;
  ex_ctrl_t         ctrl_next_s;
  ex_ctrl_t         id_ctrl_s;
  ex_data_t         data_r;
  ex_data_t         data_next_s;
  ex_data_t         id_data_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             load_use_s;

  load_use_detect u_load_use_detect (
    .ex_valid    (valid_r),
    .ex_mem_read (ctrl_r.mem_read),
    .ex_rd       (ctrl_r.reg_write_target),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .load_use    (load_use_s)
  );

  // Incoming control bundle; an invalid ID slot contributes all-zero controls.
  always_comb begin
    id_ctrl_s = '0;
    if (id_valid) begin
      id_ctrl_s.reg_write_target    = id_reg_write_target;
      id_ctrl_s.reg_write           = id_reg_write;
      id_ctrl_s.reg_write_from_load = id_reg_write_from_load;
      id_ctrl_s.alu_op_base         = id_ALU_op_base;
      id_ctrl_s.alu_op_ext          = id_ALU_op_ext;
      id_ctrl_s.alu_src             = id_ALU_src;
      id_ctrl_s.is_branch           = id_is_branch;
      id_ctrl_s.mem_write           = id_mem_write;
      id_ctrl_s.mem_read            = id_mem_read;
      id_ctrl_s.is_write_back       = id_is_write_back;
    end else begin
      id_ctrl_s = '0;
    end
  end

  // Incoming datapath bundle, captured regardless of id_valid.
  always_comb begin
    id_data_s.first_reg     = id_first_reg;
    id_data_s.second_reg    = id_second_reg;
    id_data_s.sign_extended = id_sign_extended;
    id_data_s.pc_value      = id_pc_value;
  end

  // Next-state selection. BUBBLE needs no special case: EX then holds an
  // invalid slot, so the detector cannot fire and the stalled instruction is
  // captured through the normal path. HOLD likewise re-evaluates the hazard
  // on the first cycle ext_stall is low.
  always_comb begin
    state_next_s = state_r;
    valid_next_s = valid_r;
    ctrl_next_s  = ctrl_r;
    data_next_s  = data_r;
    count_next_s = count_r;
    if (flush) begin
      valid_next_s = 1'b0;
      ctrl_next_s  = '0;
      state_next_s = ST_RUN;
    end else if (ext_stall) begin
      state_next_s = ST_HOLD;
    end else if (load_use_s) begin
      valid_next_s = 1'b0;
      ctrl_next_s  = '0;
      count_next_s = sat_inc(count_r);
      state_next_s = ST_BUBBLE;
    end else begin
      valid_next_s = id_valid;
      ctrl_next_s  = id_ctrl_s;
      data_next_s  = id_data_s;
      state_next_s = ST_RUN;
    end
  end

  // Barrier registers; reset discards whatever was held or stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RUN;
      valid_r <= 1'b0;
      ctrl_r  <= '0;
      data_r  <= '0;
      count_r <= STALL_COUNT_RST;
    end else begin
      state_r <= state_next_s;
      valid_r <= valid_next_s;
      ctrl_r  <= ctrl_next_s;
      data_r  <= data_next_s;
      count_r <= count_next_s;
    end
  end

  // A flush makes any freeze pointless: the instructions behind it are dead.
  assign hazard_stall = (load_use_s | ext_stall) & ~flush;

  assign ex_valid               = valid_r;
  assign ex_first_reg           = data_r.first_reg;
  assign ex_second_reg          = data_r.second_reg;
  assign ex_sign_extended       = data_r.sign_extended;
  assign ex_pc_value            = data_r.pc_value;
  assign ex_reg_write_target    = ctrl_r.reg_write_target;
  assign ex_reg_write           = ctrl_r.reg_write;
  assign ex_reg_write_from_load = ctrl_r.reg_write_from_load;
  assign ex_ALU_op_base         = ctrl_r.alu_op_base;
  assign ex_ALU_op_ext          = ctrl_r.alu_op_ext;
  assign ex_ALU_src             = ctrl_r.alu_src;
  assign ex_is_branch           = ctrl_r.is_branch;
  assign ex_mem_write           = ctrl_r.mem_write;
  assign ex_mem_read            = ctrl_r.mem_read;
  assign ex_is_write_back       = ctrl_r.is_write_back;
  assign stall_count            = count_r;

endmodule

// File: tb/tb_id_ex_barrier.sv
// Scoreboard bench for id_ex_barrier. The driver applies one directed vector
// per cycle on the falling edge and queues the hand-computed expectation; the
// monitor samples hazard_stall before the rising edge and the ex_* outputs
// just after it, then pops and compares. A second instance with its counter
// preset near the ceiling checks saturation.
module tb_id_ex_barrier;
  import core_pkg::*;

  typedef struct packed {
    logic        v;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rw;
    logic        rfl;
    logic [2:0]  ob;
    logic [6:0]  oe;
    logic        src;
    logic        br;
    logic        mw;
    logic        mr;
    logic        wb;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] imm;
    logic [31:0] pc;
  } instr_t;

  typedef struct packed {
    logic        chk_hz;
    logic        hz;
    logic        v;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [15:0] cnt;
    logic [15:0] sat;
    logic        chk_data;
    logic        zero_all;
  } exp_t;

  typedef struct packed {
    logic        v;
    logic [4:0]  rd;
    logic        rw;
    logic        rfl;
    logic [2:0]  ob;
    logic [6:0]  oe;
    logic        src;
    logic        br;
    logic        mw;
    logic        mr;
    logic        wb;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] imm;
    logic [31:0] pc;
    logic [15:0] cnt;
  } out_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, ext_stall;
  logic        id_valid, id_reg_write, id_reg_write_from_load, id_ALU_src;
  logic        id_is_branch, id_mem_write, id_mem_read, id_is_write_back;
  logic [4:0]  id_rs1, id_rs2, id_reg_write_target;
  logic [31:0] id_first_reg, id_second_reg, id_pc_value;
  logic [63:0] id_sign_extended;
  logic [2:0]  id_ALU_op_base;
  logic [6:0]  id_ALU_op_ext;

  logic        m_v, m_rw, m_rfl, m_src, m_br, m_mw, m_mr, m_wb, m_hz;
  logic [4:0]  m_rd;
  logic [2:0]  m_ob;
  logic [6:0]  m_oe;
  logic [31:0] m_a, m_b, m_pc;
  logic [63:0] m_imm;
  logic [15:0] m_cnt;
  logic        s_v, s_rw, s_rfl, s_src, s_br, s_mw, s_mr, s_wb, s_hz;
  logic [4:0]  s_rd;
  logic [2:0]  s_ob;
  logic [6:0]  s_oe;
  logic [31:0] s_a, s_b, s_pc;
  logic [63:0] s_imm;
  logic [15:0] s_cnt;
  out_t        m_o, s_o;

  assign m_o = {m_v, m_rd, m_rw, m_rfl, m_ob, m_oe, m_src, m_br, m_mw, m_mr, m_wb,
                m_a, m_b, m_imm, m_pc, m_cnt};
  assign s_o = {s_v, s_rd, s_rw, s_rfl, s_ob, s_oe, s_src, s_br, s_mw, s_mr, s_wb,
                s_a, s_b, s_imm, s_pc, s_cnt};

  id_ex_barrier dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_first_reg(id_first_reg), .id_second_reg(id_second_reg),
    .id_sign_extended(id_sign_extended), .id_pc_value(id_pc_value),
    .id_reg_write_target(id_reg_write_target), .id_reg_write(id_reg_write),
    .id_reg_write_from_load(id_reg_write_from_load), .id_ALU_op_base(id_ALU_op_base),
    .id_ALU_op_ext(id_ALU_op_ext), .id_ALU_src(id_ALU_src), .id_is_branch(id_is_branch),
    .id_mem_write(id_mem_write), .id_mem_read(id_mem_read),
    .id_is_write_back(id_is_write_back), .flush(flush), .ext_stall(ext_stall),
    .ex_valid(m_v), .ex_first_reg(m_a), .ex_second_reg(m_b),
    .ex_sign_extended(m_imm), .ex_pc_value(m_pc), .ex_reg_write_target(m_rd),
    .ex_reg_write(m_rw), .ex_reg_write_from_load(m_rfl), .ex_ALU_op_base(m_ob),
    .ex_ALU_op_ext(m_oe), .ex_ALU_src(m_src), .ex_is_branch(m_br),
    .ex_mem_write(m_mw), .ex_mem_read(m_mr), .ex_is_write_back(m_wb),
    .hazard_stall(m_hz), .stall_count(m_cnt)
  );

  id_ex_barrier #(.STALL_COUNT_RST(16'hFFFD)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_first_reg(id_first_reg), .id_second_reg(id_second_reg),
    .id_sign_extended(id_sign_extended), .id_pc_value(id_pc_value),
    .id_reg_write_target(id_reg_write_target), .id_reg_write(id_reg_write),
    .id_reg_write_from_load(id_reg_write_from_load), .id_ALU_op_base(id_ALU_op_base),
    .id_ALU_op_ext(id_ALU_op_ext), .id_ALU_src(id_ALU_src), .id_is_branch(id_is_branch),
    .id_mem_write(id_mem_write), .id_mem_read(id_mem_read),
    .id_is_write_back(id_is_write_back), .flush(flush), .ext_stall(ext_stall),
    .ex_valid(s_v), .ex_first_reg(s_a), .ex_second_reg(s_b),
    .ex_sign_extended(s_imm), .ex_pc_value(s_pc), .ex_reg_write_target(s_rd),
    .ex_reg_write(s_rw), .ex_reg_write_from_load(s_rfl), .ex_ALU_op_base(s_ob),
    .ex_ALU_op_ext(s_oe), .ex_ALU_src(s_src), .ex_is_branch(s_br),
    .ex_mem_write(s_mw), .ex_mem_read(s_mr), .ex_is_write_back(s_wb),
    .hazard_stall(s_hz), .stall_count(s_cnt)
  );

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_inst(input string n, input out_t o, input logic hz,
                          input exp_t e, input logic [15:0] ecnt);
    if (e.chk_hz) cmp({n, ".hazard_stall"}, 64'(hz), 64'(e.hz));
    cmp({n, ".ex_valid"}, 64'(o.v), 64'(e.v));
    cmp({n, ".ex_reg_write"}, 64'(o.rw), 64'(e.rw));
    cmp({n, ".ex_mem_read"}, 64'(o.mr), 64'(e.mr));
    cmp({n, ".ex_mem_write"}, 64'(o.mw), 64'(e.mw));
    cmp({n, ".stall_count"}, 64'(o.cnt), 64'(ecnt));
    if (!e.v)
      cmp({n, ".bubble_ctrl"},
          64'({o.rw, o.rfl, o.ob, o.oe, o.src, o.br, o.mw, o.mr, o.wb}), 64'd0);
    if (e.chk_data) begin
      cmp({n, ".ex_pc_value"}, 64'(o.pc), 64'(e.pc));
      cmp({n, ".ex_reg_write_target"}, 64'(o.rd), 64'(e.rd));
    end
    if (e.zero_all) begin
      cmp({n, ".ex_first_reg"}, 64'(o.a), 64'd0);
      cmp({n, ".ex_second_reg"}, 64'(o.b), 64'd0);
      cmp({n, ".ex_sign_extended"}, o.imm, 64'd0);
    end
  endtask

  function automatic instr_t ins(input logic v, input logic [4:0] rd, rs1, rs2,
                                 input logic rw, rfl, src, mw, mr,
                                 input logic [6:0] oe, input logic [31:0] pc);
    instr_t i;
    i.v = v; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.rw = rw; i.rfl = rfl;
    i.ob = 3'b010; i.oe = oe; i.src = src; i.br = 1'b0; i.mw = mw; i.mr = mr;
    i.wb = rw; i.a = {pc[15:0], 16'hA5A5}; i.b = ~pc;
    i.imm = {32'hFFFF_0000, pc} + 64'd4; i.pc = pc;
    return i;
  endfunction

  function automatic instr_t addi(input logic [4:0] rd, rs1, input logic [31:0] pc);
    return ins(1'b1, rd, rs1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, pc);
  endfunction
  function automatic instr_t lw(input logic [4:0] rd, rs1, input logic [31:0] pc);
    return ins(1'b1, rd, rs1, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7'h00, pc);
  endfunction
  function automatic instr_t add(input logic [4:0] rd, rs1, rs2, input logic [31:0] pc);
    return ins(1'b1, rd, rs1, rs2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, pc);
  endfunction
  function automatic instr_t sub(input logic [4:0] rd, rs1, rs2, input logic [31:0] pc);
    return ins(1'b1, rd, rs1, rs2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'h20, pc);
  endfunction
  function automatic instr_t sw(input logic [4:0] rs1, rs2, input logic [31:0] pc);
    return ins(1'b1, 5'd0, rs1, rs2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'h00, pc);
  endfunction
  // Invalid slot with write enables raised, to prove they are masked.
  function automatic instr_t bub(input logic [31:0] pc);
    return ins(1'b0, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7'h00, pc);
  endfunction

  function automatic exp_t ex(input logic hz, v, input logic [31:0] pc,
                              input logic [4:0] rd, input logic rw, mr, mw,
                              input logic [15:0] cnt, sat);
    exp_t e;
    e.chk_hz = 1'b1; e.hz = hz; e.v = v; e.pc = pc; e.rd = rd; e.rw = rw;
    e.mr = mr; e.mw = mw; e.cnt = cnt; e.sat = sat; e.chk_data = v; e.zero_all = 1'b0;
    return e;
  endfunction

  function automatic exp_t exr(input logic chk_hz, input logic [15:0] sat);
    exp_t e;
    e = ex(1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 16'd0, sat);
    e.chk_hz = chk_hz; e.chk_data = 1'b1; e.zero_all = 1'b1;
    return e;
  endfunction

  task automatic apply(input instr_t i, input logic r, fl, st);
    rst = r; flush = fl; ext_stall = st;
    id_valid = i.v; id_rs1 = i.rs1; id_rs2 = i.rs2; id_reg_write_target = i.rd;
    id_reg_write = i.rw; id_reg_write_from_load = i.rfl; id_ALU_op_base = i.ob;
    id_ALU_op_ext = i.oe; id_ALU_src = i.src; id_is_branch = i.br;
    id_mem_write = i.mw; id_mem_read = i.mr; id_is_write_back = i.wb;
    id_first_reg = i.a; id_second_reg = i.b; id_sign_extended = i.imm;
    id_pc_value = i.pc;
  endtask

  task automatic cyc(input instr_t i, input logic r, fl, st, input exp_t e);
    @(negedge clk);
    apply(i, r, fl, st);
    q.push_back(e);
  endtask

  // Monitor: hazard sampled late in the low phase, registers just after the edge.
  initial begin
    exp_t e;
    logic mh, sh;
    forever begin
      @(negedge clk);
      #2;
      mh = m_hz;
      sh = s_hz;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk_inst("dut", m_o, mh, e, e.cnt);
        chk_inst("sat", s_o, sh, e, e.sat);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Driver: directed vectors with hand-computed expectations.
  initial begin
    apply(bub(32'd0), 1'b1, 1'b0, 1'b0);
    // Reset: everything cleared; hazard unknown before the first edge.
    cyc(bub(32'd0), 1'b1, 1'b0, 1'b0, exr(1'b0, 16'hFFFD));
    cyc(bub(32'd0), 1'b1, 1'b0, 1'b0, exr(1'b1, 16'hFFFD));
    // addi x5 at 0x10 appears one cycle later.
    cyc(addi(5'd5, 5'd0, 32'h10), 1'b0, 1'b0, 1'b0,
        ex(1'b0, 1'b1, 32'h10, 5'd5, 1'b1, 1'b0, 1'b0, 16'd0, 16'hFFFD));
    // lw x6 then add x7,x6,x1: one bubble, count 1, add follows.
    cyc(lw(5'd6, 5'd2, 32'h14), 1'b0, 1'b0, 1'b0,
        ex(1'b0, 1'b1, 32'h14, 5'd6, 1'b1, 1'b1, 1'b0, 16'd0, 16'hFFFD));
    cyc(add(5'd7, 5'd6, 5'd1, 32'h18), 1'b0, 1'b0, 1'b0,
        ex(1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 16'd1, 16'hFFFE));
    cyc(add(5'd7, 5'd6, 5'd1, 32'h18), 1'b0, 1'b0, 1'b0,
        ex(1'b0, 1'b1, 32'h18, 5'd7, 1'b1, 1'b0, 1'b0, 16'd1, 16'hFFFE));
    // lw x0 then add x7,x0,x1: no hazard through x0.
    cyc(lw(5'd0, 5'd2, 32'h1C), 1'b0, 1'b0, 1'b0,
        ex(1'b0, 1'b1, 32'h1C, 5'd0, 1'b1, 1'b1, 1'b0, 16'd1, 16'hFFFE));
    cyc(add(5'd7, 5'd0, 5'd1, 32'h20), 1'b0, 1'b0, 1'b0,
        ex(1'b0, 1'b1, 32'h20, 5'd7, 1'b1, 1'b0, 1'b0, 16'd1, 16'hFFFE));
    // sub in EX frozen by ext_stall for three cycles, then next captured.
    cyc(sub(5'd8, 5'd7, 5'd3, 32'h24), 1'b0, 1'b0, 1'b0,
        ex(1'b0, 1'b1, 32'h24, 5'd8, 1'b1, 1'b0, 1'b0, 16'd1, 16'hFFFE));
    for (int k = 0; k < 3; k++)
      cyc(add(5'd9, 5'd4, 5'd5, 32'h28), 1'b0, 1'b0, 1'b1,
          ex(1'b1, 1'b1, 32'h24, 5'd8, 1'b1, 1'b0, 1'b0, 16'd1, 16'hFFFE));
    cyc(add(5'd9, 5'd4, 5'd5, 32'h28), 1'b0, 1'b0, 1'b0,
        ex(1'b0, 1'b1, 32'h28, 5'd9, 1'b1, 1'b0, 1'b0, 16'd1, 16'hFFFE));
    // Invalid ID slot: bubble with controls masked and no count.
    cyc(bub(32'h2C), 1'b0, 1'b0, 1'b0,
        ex(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 16'd1, 16'hFFFE));
    // Hazard pending under ext_stall, resolved when the stall drops.
    cyc(lw(5'd10, 5'd1, 32'h2C), 1'b0, 1'b0, 1'b0,
        ex(1'b0, 1'b1, 32'h2C, 5'd10, 1'b1, 1'b1, 1'b0, 16'd1, 16'hFFFE));
    cyc(add(5'd11, 5'd10, 5'd0, 32'h30), 1'b0, 1'b0, 1'b1,
        ex(1'b1, 1'b1, 32'h2C, 5'd10, 1'b1, 1'b1, 1'b0, 16'd1, 16'hFFFE));
    cyc(add(5'd11, 5'd10, 5'd0, 32'h30), 1'b0, 1'b0, 1'b0,
        ex(1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 16'd2, 16'hFFFF));
    cyc(add(5'd11, 5'd10, 5'd0, 32'h30), 1'b0, 1'b0, 1'b0,
        ex(1'b0, 1'b1, 32'h30, 5'd11, 1'b1, 1'b0, 1'b0, 16'd2, 16'hFFFF));
    // Flush + ext_stall with load-use pending: flush wins, no count.
    cyc(lw(5'd12, 5'd1, 32'h34), 1'b0, 1'b0, 1'b0,
        ex(1'b0, 1'b1, 32'h34, 5'd12, 1'b1, 1'b1, 1'b0, 16'd2, 16'hFFFF));
    cyc(sw(5'd2, 5'd12, 32'h38), 1'b0, 1'b1, 1'b1,
        ex(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 16'd2, 16'hFFFF));
    cyc(add(5'd13, 5'd1, 5'd2, 32'h3C), 1'b0, 1'b0, 1'b0,
        ex(1'b0, 1'b1, 32'h3C, 5'd13, 1'b1, 1'b0, 1'b0, 16'd2, 16'hFFFF));
    // Further hazards: preset counter stays pinned at FFFF.
    cyc(lw(5'd14, 5'd1, 32'h40), 1'b0, 1'b0, 1'b0,
        ex(1'b0, 1'b1, 32'h40, 5'd14, 1'b1, 1'b1, 1'b0, 16'd2, 16'hFFFF));
    cyc(add(5'd15, 5'd14, 5'd0, 32'h44), 1'b0, 1'b0, 1'b0,
        ex(1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 16'd3, 16'hFFFF));
    cyc(add(5'd15, 5'd14, 5'd0, 32'h44), 1'b0, 1'b0, 1'b0,
        ex(1'b0, 1'b1, 32'h44, 5'd15, 1'b1, 1'b0, 1'b0, 16'd3, 16'hFFFF));
    cyc(lw(5'd16, 5'd1, 32'h48), 1'b0, 1'b0, 1'b0,
        ex(1'b0, 1'b1, 32'h48, 5'd16, 1'b1, 1'b1, 1'b0, 16'd3, 16'hFFFF));
    cyc(add(5'd17, 5'd0, 5'd16, 32'h4C), 1'b0, 1'b0, 1'b0,
        ex(1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 16'd4, 16'hFFFF));
    // Reset while in BUBBLE: all outputs cleared, then normal capture.
    cyc(add(5'd17, 5'd0, 5'd16, 32'h4C), 1'b1, 1'b0, 1'b0, exr(1'b1, 16'hFFFD));
    cyc(add(5'd17, 5'd0, 5'd16, 32'h4C), 1'b0, 1'b0, 1'b0,
        ex(1'b0, 1'b1, 32'h4C, 5'd17, 1'b1, 1'b0, 1'b0, 16'd0, 16'hFFFD));
    repeat (3) @(negedge clk);
    cmp("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
